fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the register file / ALU datapath. Holds the program counter, issues word-addressed reads to instruction memory over a req/ack handshake, and buffers returned instructions, tagged with their PC, in a small FIFO. The FIFO feeds decode through a valid/ready interface. A redirect input restarts fetch at a new PC and discards everything fetched down the old path.

---
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack, redirect, and the decode-facing FIFO head.
// The fetch unit uses the master view; whatever sits around it uses the slave view.
interface fetch_unit_if #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned DEPTH   = 4
) ();
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic               mem_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_ack;
   logic [INSTR_W-1:0] mem_rdata;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   logic [CNT_W-1:0]   count;

   modport master (
      output mem_req, mem_addr,
      input  mem_ack, mem_rdata,
      input  redirect_valid, redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr, out_pc, count
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_ack, mem_rdata,
      output redirect_valid, redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr, out_pc, count
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory read, and a PC-tagged instruction FIFO
// toward decode. A redirect restarts fetch at a new PC and flushes the old path.
module fetch_unit #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned INSTR_W  = 32,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   fetch_unit_if.master   bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic               mem_req_q, mem_req_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               out_valid_q, out_valid_d;
   logic [INSTR_W-1:0] instr_q [DEPTH];
   logic [INSTR_W-1:0] instr_d [DEPTH];
   logic [ADDR_W-1:0]  pc_q    [DEPTH];
   logic [ADDR_W-1:0]  pc_d    [DEPTH];
   logic               push;
   logic               pop;

   // Redirect wins over a returning ack; data from a dropped request never reaches the FIFO.
   assign push = (state_q == WAIT) && bus.mem_ack && !bus.redirect_valid;
   assign pop  = out_valid_q && bus.out_ready;

   // Fetch control: issue, back-to-back streaming, and redirect recovery.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_addr_d = mem_addr_q;
      unique case (state_q)
         IDLE: begin
            if (bus.redirect_valid) begin
               fetch_pc_d = bus.redirect_pc;
            end else if (count_q < FULL_CNT) begin
               mem_addr_d = fetch_pc_q;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (bus.redirect_valid) begin
               fetch_pc_d = bus.redirect_pc;
               state_d    = bus.mem_ack ? IDLE : DROP;
            end else if (bus.mem_ack) begin
               fetch_pc_d = mem_addr_q + ADDR_W'(1);
               if ((count_q + CNT_W'(1) - CNT_W'(pop)) < FULL_CNT) begin
                  mem_addr_d = mem_addr_q + ADDR_W'(1);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DROP: begin
            if (bus.redirect_valid) begin
               fetch_pc_d = bus.redirect_pc;
            end
            if (bus.mem_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      mem_req_d = (state_d != IDLE);
   end

   // FIFO bookkeeping; a redirect empties it regardless of push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      instr_d  = instr_q;
      pc_d     = pc_q;
      if (bus.redirect_valid) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            instr_d[wr_ptr_q] = bus.mem_rdata;
            pc_d[wr_ptr_q]    = mem_addr_q;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
      out_valid_d = (count_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_ADDR;
         mem_addr_q <= '0;
         mem_req_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         pc_q        <= pc_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.count     = count_q;
   assign bus.out_instr = instr_q[rd_ptr_q];
   assign bus.out_pc    = pc_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a path-level model predicts which instructions decode sees,
// plus directed checks for reset, backpressure, redirect timing and PC wrap-around.
module tb_fetch_unit;
   localparam int unsigned AW = 16;
   localparam int unsigned IW = 32;
   localparam int unsigned DP = 4;

   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DP)) bus ();
   fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DP)) bus_w ();

   fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DP), .RESET_PC(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DP), .RESET_PC(32'hFFFE)) u_wrap (
      .clk(clk), .rst_n(rst_n), .bus(bus_w));

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {a ^ 16'h5A5A, ~a + 16'h1234};
   endfunction

   assign bus.mem_rdata   = mem_word(bus.mem_addr);
   assign bus_w.mem_rdata = mem_word(bus_w.mem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Memory responder / decode driver, applied just after each rising edge.
   int ack_mode = 0;   // 0: always ack, 1: random ack, 2: ack 3 cycles after request
   int rdy_mode = 1;   // 0: stalled, 1: always ready, 2: random
   int wcnt     = 0;
   initial begin
      bus.mem_ack = 1'b0;
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk); #2;
         case (ack_mode)
            0: bus.mem_ack = 1'b1;
            1: bus.mem_ack = ($urandom_range(0, 99) < 60);
            default: begin
               if (!bus.mem_req) begin
                  wcnt = 0; bus.mem_ack = 1'b0;
               end else if (wcnt == 3) begin
                  wcnt = 0; bus.mem_ack = 1'b1;
               end else begin
                  wcnt++; bus.mem_ack = 1'b0;
               end
            end
         endcase
         case (rdy_mode)
            0: bus.out_ready = 1'b0;
            1: bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 99) < 70);
         endcase
      end
   end

   // Reference model: decode must see consecutive PCs from the last restart point, nothing older.
   logic [47:0] expq[$];
   logic [15:0] exp_pc = 16'h0000;
   bit          stale = 1'b0;
   bit          prev_req = 1'b0;
   bit          prev_ack = 1'b0;
   logic [15:0] prev_addr = 16'h0000;
   int          pops = 0;

   always @(negedge clk) begin : model
      logic [47:0] hd;
      if (!rst_n) begin
         expq.delete();
         stale    = 1'b0;
         exp_pc   = 16'h0000;
         prev_req = 1'b0;
         prev_ack = 1'b0;
      end else begin
         chk("count", 64'(bus.count), 64'(expq.size()));
         chk("out_valid", 64'(bus.out_valid), 64'(expq.size() != 0));
         if (prev_req && !prev_ack) begin
            chk("req_hold", 64'(bus.mem_req), 64'(1));
            chk("addr_hold", 64'(bus.mem_addr), 64'(prev_addr));
         end
         if (bus.out_valid && bus.out_ready && expq.size() != 0) begin
            hd = expq.pop_front();
            pops++;
            chk("pop_pc", 64'(bus.out_pc), 64'(hd[47:32]));
            chk("pop_instr", 64'(bus.out_instr), 64'(hd[31:0]));
         end
         if (bus.redirect_valid) begin
            expq.delete();
            stale  = bus.mem_req && !bus.mem_ack;
            exp_pc = bus.redirect_pc;
         end else if (bus.mem_req && bus.mem_ack) begin
            if (stale) begin
               stale = 1'b0;
            end else begin
               chk("fetch_addr", 64'(bus.mem_addr), 64'(exp_pc));
               expq.push_back({exp_pc, mem_word(exp_pc)});
               exp_pc = exp_pc + 16'd1;
            end
         end
         prev_req  = bus.mem_req;
         prev_ack  = bus.mem_ack;
         prev_addr = bus.mem_addr;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [15:0] nxt;
      bit          found;
      rst_n = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      bus_w.mem_ack = 1'b1;
      bus_w.out_ready = 1'b1;
      bus_w.redirect_valid = 1'b0;
      bus_w.redirect_pc = '0;
      ack_mode = 0;
      rdy_mode = 1;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_mem_req", 64'(bus.mem_req), 64'(0));
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_count", 64'(bus.count), 64'(0));
      chk("rst_out_instr", 64'(bus.out_instr), 64'(0));
      chk("rst_out_pc", 64'(bus.out_pc), 64'(0));

      // Zero-wait streaming, plus the wrap-around instance
      @(posedge clk); #2; rst_n = 1'b1;
      @(negedge clk);
      chk("first_req_not_early", 64'(bus.mem_req), 64'(0));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stream_req", 64'(bus.mem_req), 64'(1));
         chk("stream_addr", 64'(bus.mem_addr), 64'(i));
         chk("wrap_addr", 64'(bus_w.mem_addr), 64'(16'(32'hFFFE + i)));
         if (i > 0) begin
            chk("stream_out_valid", 64'(bus.out_valid), 64'(1));
            chk("stream_out_pc", 64'(bus.out_pc), 64'(i - 1));
            chk("wrap_out_pc", 64'(bus_w.out_pc), 64'(16'(32'hFFFE + i - 1)));
         end
      end

      // Backpressure fills the FIFO, then one pop re-opens fetch
      rdy_mode = 0;
      repeat (10) @(negedge clk);
      chk("full_count", 64'(bus.count), 64'(4));
      chk("full_no_req", 64'(bus.mem_req), 64'(0));
      rdy_mode = 1;
      @(negedge clk);
      rdy_mode = 0;
      chk("full_count_hold", 64'(bus.count), 64'(4));
      @(negedge clk);
      chk("one_pop_count", 64'(bus.count), 64'(3));
      chk("one_pop_no_req_yet", 64'(bus.mem_req), 64'(0));
      nxt = exp_pc;
      @(negedge clk);
      chk("refill_req", 64'(bus.mem_req), 64'(1));
      chk("refill_addr", 64'(bus.mem_addr), 64'(nxt));

      // Memory wait states
      ack_mode = 2;
      rdy_mode = 2;
      repeat (40) @(negedge clk);

      // Redirect to 0x40 while the request at 0x05 is still outstanding
      rdy_mode = 1;
      @(posedge clk); #2; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0005;
      @(posedge clk); #2; bus.redirect_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (bus.mem_req && bus.mem_addr == 16'h0005 && !bus.mem_ack) found = 1'b1;
      end
      chk("req5_seen", 64'(found), 64'(1));
      @(posedge clk); #2; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0040;
      @(posedge clk); #2; bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk("drop_out_valid", 64'(bus.out_valid), 64'(0));
      chk("drop_req", 64'(bus.mem_req), 64'(1));
      chk("drop_addr", 64'(bus.mem_addr), 64'(16'h0005));
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.mem_req && bus.mem_addr != 16'h0005) found = 1'b1;
      end
      chk("after_drop_seen", 64'(found), 64'(1));
      chk("after_drop_addr", 64'(bus.mem_addr), 64'(16'h0040));

      // Redirect coincident with an ack
      ack_mode = 0;
      repeat (8) @(negedge clk);
      chk("coinc_pre_req", 64'(bus.mem_req), 64'(1));
      @(posedge clk); #2; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0100;
      @(posedge clk); #2; bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk("coinc_idle", 64'(bus.mem_req), 64'(0));
      chk("coinc_out_valid", 64'(bus.out_valid), 64'(0));
      @(negedge clk);
      chk("coinc_req", 64'(bus.mem_req), 64'(1));
      chk("coinc_addr", 64'(bus.mem_addr), 64'(16'h0100));

      // Random traffic with redirects and one mid-flight reset
      ack_mode = 1;
      rdy_mode = 2;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #2;
         if (i == 250) begin
            bus.redirect_valid = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            chk("midrst_req", 64'(bus.mem_req), 64'(0));
            chk("midrst_addr", 64'(bus.mem_addr), 64'(0));
            chk("midrst_count", 64'(bus.count), 64'(0));
            chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
            chk("midrst_out_pc", 64'(bus.out_pc), 64'(0));
            chk("midrst_out_instr", 64'(bus.out_instr), 64'(0));
            @(posedge clk); #2;
            rst_n = 1'b1;
         end else begin
            bus.redirect_valid = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 3) == 0)
               bus.redirect_pc = 16'hFFFC + 16'($urandom_range(0, 3));
            else
               bus.redirect_pc = 16'($urandom_range(0, 65535));
         end
      end
      @(posedge clk); #2; bus.redirect_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("progress", 64'(pops > 50), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
